// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// MemWB stage and an out-of-order long-latency unit. MemWB always wins the port.
// A long-unit result waits in a one-entry hold buffer until the port is free.
// A per-register scoreboard of pending long-unit writes drives the decode stall.
module wb_port_arbiter #(
    parameter int REGS_NUM   = 32,
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     pipe_data_in,
    input  logic [7:0]          pipe_wr_id_in,
    input  logic                pipe_write_in,
    input  logic                lu_issue_in,
    input  logic [7:0]          lu_issue_rd_in,
    input  logic                lu_valid_in,
    input  logic [XLEN-1:0]     lu_data_in,
    input  logic [7:0]          lu_rd_in,
    output logic                lu_ready_out,
    input  logic [7:0]          rs1_id_in,
    input  logic [7:0]          rs2_id_in,
    input  logic [7:0]          rd_id_in,
    output logic                stall_out,
    output logic [REGS_NUM-1:0] busy_out,
    output logic [XLEN-1:0]     regs_data_out,
    output logic [7:0]          regs_wr_id_out,
    output logic                regs_write_out
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic                hold_valid;
    logic [XLEN-1:0]     hold_data;
    logic [7:0]          hold_rd;
    logic [REGS_NUM-1:0] busy;
    logic [REGS_NUM-1:0] busy_next;
    logic [CNT_W-1:0]    starve_cnt;
    logic                starve;

    logic pipe_busy;
    logic drain;
    logic accept;
    logic issue_set;

    // Looks up one scoreboard bit; x0 and out-of-range indices read as not busy.
    function automatic logic busy_at(input logic [REGS_NUM-1:0] vec, input logic [7:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < REGS_NUM; i++) begin
            if (idx == 8'(i)) begin
                hit = vec[i];
            end
        end
        return hit;
    endfunction

    // Port arbitration decisions; a write to x0 does not occupy the port.
    always_comb begin
        pipe_busy = pipe_write_in && (pipe_wr_id_in != 8'd0);
        drain     = hold_valid && !pipe_busy;
        accept    = lu_valid_in && !hold_valid;
        issue_set = lu_issue_in && (lu_issue_rd_in != 8'd0);
    end

    // Scoreboard update: a drain clears its register, an issue sets its register, set wins.
    always_comb begin
        busy_next = busy;
        for (int i = 1; i < REGS_NUM; i++) begin
            if (drain && (hold_rd == 8'(i))) begin
                busy_next[i] = 1'b0;
            end
            if (issue_set && (lu_issue_rd_in == 8'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    // Register-file write port: pipe first, then the held result, else idle.
    always_comb begin
        regs_write_out = 1'b0;
        regs_wr_id_out = 8'd0;
        regs_data_out  = '0;
        if (!reset) begin
            if (pipe_busy) begin
                regs_write_out = 1'b1;
                regs_wr_id_out = pipe_wr_id_in;
                regs_data_out  = pipe_data_in;
            end else if (hold_valid && (hold_rd != 8'd0)) begin
                regs_write_out = 1'b1;
                regs_wr_id_out = hold_rd;
                regs_data_out  = hold_data;
            end
        end
    end

    // Handshake and decode stall, both forced low while reset is held.
    always_comb begin
        lu_ready_out = !reset && !hold_valid;
        stall_out    = !reset && (busy_at(busy, rs1_id_in) || busy_at(busy, rs2_id_in) ||
                                  busy_at(busy, rd_id_in) || starve);
        busy_out     = busy;
    end

    // Hold buffer, scoreboard and starvation tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_rd    <= 8'd0;
            busy       <= '0;
            starve_cnt <= '0;
            starve     <= 1'b0;
        end else begin
            busy <= busy_next;
            if (drain) begin
                hold_valid <= 1'b0;
                starve_cnt <= '0;
                starve     <= 1'b0;
            end else if (hold_valid) begin
                if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
                if (starve_cnt >= CNT_W'(STARVE_MAX - 1)) begin
                    starve <= 1'b1;
                end
            end
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= lu_data_in;
                hold_rd    <= lu_rd_in;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a queue-based model.
module tb_wb_port_arbiter;

    localparam int REGS_NUM   = 32;
    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 8;

    logic                clk;
    logic                reset;
    logic [XLEN-1:0]     pipe_data_in;
    logic [7:0]          pipe_wr_id_in;
    logic                pipe_write_in;
    logic                lu_issue_in;
    logic [7:0]          lu_issue_rd_in;
    logic                lu_valid_in;
    logic [XLEN-1:0]     lu_data_in;
    logic [7:0]          lu_rd_in;
    logic                lu_ready_out;
    logic [7:0]          rs1_id_in;
    logic [7:0]          rs2_id_in;
    logic [7:0]          rd_id_in;
    logic                stall_out;
    logic [REGS_NUM-1:0] busy_out;
    logic [XLEN-1:0]     regs_data_out;
    logic [7:0]          regs_wr_id_out;
    logic                regs_write_out;

    int compared;
    int mismatched;

    wb_port_arbiter #(.REGS_NUM(REGS_NUM), .XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .pipe_data_in(pipe_data_in), .pipe_wr_id_in(pipe_wr_id_in), .pipe_write_in(pipe_write_in),
        .lu_issue_in(lu_issue_in), .lu_issue_rd_in(lu_issue_rd_in),
        .lu_valid_in(lu_valid_in), .lu_data_in(lu_data_in), .lu_rd_in(lu_rd_in),
        .lu_ready_out(lu_ready_out),
        .rs1_id_in(rs1_id_in), .rs2_id_in(rs2_id_in), .rd_id_in(rd_id_in),
        .stall_out(stall_out), .busy_out(busy_out),
        .regs_data_out(regs_data_out), .regs_wr_id_out(regs_wr_id_out),
        .regs_write_out(regs_write_out)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison; prints a FAIL line on disagreement.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: pending results as a queue, pending registers as a set,
    // and the number of cycles the oldest held result has been refused the port.
    typedef struct {
        logic [7:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t              hold_q[$];
    bit [REGS_NUM-1:0]   pend;
    int                  wait_cycles;

    function automatic bit pend_at(input logic [7:0] idx);
        return (idx != 8'd0) && (int'(idx) < REGS_NUM) && pend[int'(idx)];
    endfunction

    // Per-cycle compare against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        bit              pb;
        bit              exp_wr;
        logic [7:0]      exp_id;
        logic [XLEN-1:0] exp_data;
        bit              exp_rdy;
        bit              exp_stall;
        entry_t          e;

        pb       = pipe_write_in && (pipe_wr_id_in != 8'd0);
        exp_wr   = 1'b0;
        exp_id   = 8'd0;
        exp_data = '0;
        if (!reset) begin
            if (pb) begin
                exp_wr = 1'b1; exp_id = pipe_wr_id_in; exp_data = pipe_data_in;
            end else if (hold_q.size() > 0 && hold_q[0].rd != 8'd0) begin
                exp_wr = 1'b1; exp_id = hold_q[0].rd; exp_data = hold_q[0].data;
            end
        end
        exp_rdy   = !reset && (hold_q.size() == 0);
        exp_stall = !reset && (pend_at(rs1_id_in) || pend_at(rs2_id_in) || pend_at(rd_id_in) ||
                               wait_cycles >= STARVE_MAX);

        check_output("model_write", 64'(regs_write_out), 64'(exp_wr));
        check_output("model_wr_id", 64'(regs_wr_id_out), 64'(exp_id));
        check_output("model_data",  64'(regs_data_out),  64'(exp_data));
        check_output("model_ready", 64'(lu_ready_out),   64'(exp_rdy));
        check_output("model_stall", 64'(stall_out),      64'(exp_stall));
        check_output("model_busy",  64'(busy_out),       64'(pend));

        if (reset) begin
            hold_q.delete();
            pend        = '0;
            wait_cycles = 0;
        end else begin
            if (hold_q.size() > 0) begin
                if (!pb) begin
                    if (int'(hold_q[0].rd) < REGS_NUM) pend[int'(hold_q[0].rd)] = 1'b0;
                    void'(hold_q.pop_front());
                    wait_cycles = 0;
                end else begin
                    wait_cycles++;
                end
            end
            if (lu_valid_in && exp_rdy) begin
                e.rd = lu_rd_in; e.data = lu_data_in;
                hold_q.push_back(e);
            end
            if (lu_issue_in && lu_issue_rd_in != 8'd0 && int'(lu_issue_rd_in) < REGS_NUM)
                pend[int'(lu_issue_rd_in)] = 1'b1;
            pend[0] = 1'b0;
        end
    end

    // Drives all inputs to an idle state.
    task automatic set_idle();
        pipe_write_in = 0; pipe_wr_id_in = 0; pipe_data_in = 0;
        lu_issue_in = 0; lu_issue_rd_in = 0;
        lu_valid_in = 0; lu_rd_in = 0; lu_data_in = 0;
        rs1_id_in = 0; rs2_id_in = 0; rd_id_in = 0;
    endtask

    // Advances to just after the next active edge, where inputs may change.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
    endtask

    // Random input pattern for one cycle, including out-of-range register ids.
    task automatic randomize_inputs();
        pipe_write_in  = ($urandom_range(0, 99) < 60);
        pipe_wr_id_in  = 8'($urandom_range(0, 35));
        pipe_data_in   = $urandom;
        lu_issue_in    = ($urandom_range(0, 99) < 30);
        lu_issue_rd_in = 8'($urandom_range(0, 35));
        lu_valid_in    = ($urandom_range(0, 99) < 40);
        lu_rd_in       = 8'($urandom_range(0, 35));
        lu_data_in     = $urandom;
        rs1_id_in      = 8'($urandom_range(0, 35));
        rs2_id_in      = 8'($urandom_range(0, 35));
        rd_id_in       = 8'($urandom_range(0, 35));
        reset          = ($urandom_range(0, 199) == 0);
    endtask

    // Directed scenarios with hand-computed values, then random traffic.
    initial begin
        compared = 0; mismatched = 0;
        hold_q.delete(); pend = '0; wait_cycles = 0;
        reset = 1'b1;
        set_idle();
        repeat (2) @(negedge clk);
        check_output("rst_ready", 64'(lu_ready_out), 64'd0);
        check_output("rst_write", 64'(regs_write_out), 64'd0);
        apply_stimulus();
        reset = 1'b0;
        @(negedge clk);
        check_output("init_ready", 64'(lu_ready_out), 64'd1);
        check_output("init_busy", 64'(busy_out), 64'd0);

        // Pipe write to x5 goes straight through
        apply_stimulus();
        pipe_write_in = 1; pipe_wr_id_in = 8'd5; pipe_data_in = 32'h11;
        @(negedge clk);
        check_output("t1_write", 64'(regs_write_out), 64'd1);
        check_output("t1_id", 64'(regs_wr_id_out), 64'd5);
        check_output("t1_data", 64'(regs_data_out), 64'h11);

        // Issue x7, result returns later, pipe idle
        apply_stimulus();
        set_idle();
        lu_issue_in = 1; lu_issue_rd_in = 8'd7;
        apply_stimulus();
        lu_issue_in = 0; rs1_id_in = 8'd7;
        @(negedge clk);
        check_output("t2_busy7", 64'(busy_out[7]), 64'd1);
        check_output("t2_stall", 64'(stall_out), 64'd1);
        repeat (3) apply_stimulus();
        lu_valid_in = 1; lu_rd_in = 8'd7; lu_data_in = 32'hABCD;
        @(negedge clk);
        check_output("t2_ready_acc", 64'(lu_ready_out), 64'd1);
        apply_stimulus();
        lu_valid_in = 0;
        @(negedge clk);
        check_output("t2_write", 64'(regs_write_out), 64'd1);
        check_output("t2_id", 64'(regs_wr_id_out), 64'd7);
        check_output("t2_data", 64'(regs_data_out), 64'hABCD);
        check_output("t2_ready_hold", 64'(lu_ready_out), 64'd0);
        apply_stimulus();
        @(negedge clk);
        check_output("t2_busy7_clr", 64'(busy_out[7]), 64'd0);
        check_output("t2_ready_back", 64'(lu_ready_out), 64'd1);
        check_output("t2_stall_clr", 64'(stall_out), 64'd0);

        // x9 held while the pipe writes every cycle until starvation stalls decode
        apply_stimulus();
        set_idle();
        lu_valid_in = 1; lu_rd_in = 8'd9; lu_data_in = 32'h99;
        pipe_write_in = 1; pipe_wr_id_in = 8'd2; pipe_data_in = 32'h22;
        apply_stimulus();
        lu_valid_in = 0;
        for (int i = 1; i <= STARVE_MAX; i++) begin
            apply_stimulus();
            @(negedge clk);
            check_output("t3_starve_stall", 64'(stall_out), (i == STARVE_MAX) ? 64'd1 : 64'd0);
            check_output("t3_pipe_id", 64'(regs_wr_id_out), 64'd2);
        end
        apply_stimulus();
        pipe_write_in = 0;
        @(negedge clk);
        check_output("t3_drain_id", 64'(regs_wr_id_out), 64'd9);
        check_output("t3_drain_data", 64'(regs_data_out), 64'h99);
        apply_stimulus();
        @(negedge clk);
        check_output("t3_stall_drop", 64'(stall_out), 64'd0);

        // Result for x0 is accepted and dropped without a write
        apply_stimulus();
        lu_valid_in = 1; lu_rd_in = 8'd0; lu_data_in = 32'h5555;
        apply_stimulus();
        lu_valid_in = 0;
        @(negedge clk);
        check_output("t4_nowrite", 64'(regs_write_out), 64'd0);
        check_output("t4_ready_low", 64'(lu_ready_out), 64'd0);
        apply_stimulus();
        @(negedge clk);
        check_output("t4_ready_back", 64'(lu_ready_out), 64'd1);

        // Reissue x3 in the cycle its held result drains: busy stays set
        apply_stimulus();
        lu_issue_in = 1; lu_issue_rd_in = 8'd3;
        apply_stimulus();
        lu_issue_in = 0;
        lu_valid_in = 1; lu_rd_in = 8'd3; lu_data_in = 32'h33;
        apply_stimulus();
        lu_valid_in = 0;
        lu_issue_in = 1; lu_issue_rd_in = 8'd3;
        @(negedge clk);
        check_output("t5_drain_id", 64'(regs_wr_id_out), 64'd3);
        apply_stimulus();
        lu_issue_in = 0;
        @(negedge clk);
        check_output("t5_busy3", 64'(busy_out[3]), 64'd1);

        // Reset with a held result and x4 pending
        apply_stimulus();
        lu_issue_in = 1; lu_issue_rd_in = 8'd4;
        apply_stimulus();
        lu_issue_in = 0;
        pipe_write_in = 1; pipe_wr_id_in = 8'd1; pipe_data_in = 32'h1;
        lu_valid_in = 1; lu_rd_in = 8'd8; lu_data_in = 32'h88;
        apply_stimulus();
        lu_valid_in = 0;
        reset = 1; rd_id_in = 8'd4;
        @(negedge clk);
        check_output("t6_rst_stall", 64'(stall_out), 64'd0);
        check_output("t6_rst_write", 64'(regs_write_out), 64'd0);
        apply_stimulus();
        reset = 0; pipe_write_in = 0;
        @(negedge clk);
        check_output("t6_busy", 64'(busy_out), 64'd0);
        check_output("t6_write", 64'(regs_write_out), 64'd0);
        check_output("t6_ready", 64'(lu_ready_out), 64'd1);

        // Random traffic; the model process checks every cycle
        for (int n = 0; n < 3000; n++) begin
            apply_stimulus();
            randomize_inputs();
        end
        apply_stimulus();
        set_idle();
        reset = 0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
